// File: rtl/adder_sum_stage.sv
`default_nettype none
// ============================================================================
// Module   : adder_sum_stage
// Brief    : Two-stage sum/flag stage fed by the group-level prefix tree of
//            the parallel-prefix adder. Stage 1 registers bit P/G, carry-in
//            and per-group carry-ins. Stage 2 ripples carries inside each
//            group and registers sum, carry-out and ALU flags. The pipeline
//            has a valid/ready handshake with full back-pressure.
// Config   : define ADDER_SUM_FLAGS_EN to build the ovf/zero/neg flag logic.
//            When it is left undefined, those outputs are tied low.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef INPUTSIZE
`define INPUTSIZE 32
`endif
`ifndef GROUPSIZE
`define GROUPSIZE 4
`endif

module adder_sum_stage #(
    parameter int WIDTH = `INPUTSIZE,     // operand width
    parameter int GROUP = `GROUPSIZE,     // bits per carry group (WIDTH % GROUP == 0)
    parameter int NGRP  = WIDTH / GROUP   // number of carry groups
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    p,
    input  logic [WIDTH-1:0]    g,
    input  logic                cin,
    input  logic [2*NGRP-1:0]   q_gp,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    sum,
    output logic                cout,
    output logic                ovf,
    output logic                zero,
    output logic                neg
);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic               w_adv;        // stage 1 may move into the output stage
    logic               r_s1_valid;
    logic               r_out_valid;

    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_adv;
    assign out_valid = r_out_valid;

    // ------------------------------------------------------------------
    // Stage 1: group carry-ins from the prefix pairs
    // ------------------------------------------------------------------
    logic [NGRP:0]      w_cg;         // w_cg[NGRP] is the adder carry-out

    // Group i starts with the carry out of groups 0..i-1 plus carry-in
    always_comb begin
        w_cg    = '0;
        w_cg[0] = cin;
        for (int i = 1; i <= NGRP; i++) begin
            w_cg[i] = q_gp[2*i-1] | (q_gp[2*i-2] & cin);
        end
    end

    logic [WIDTH-1:0]   r_s1_p;
    logic [WIDTH-1:0]   r_s1_g;
    logic [NGRP-1:0]    r_s1_cg;
    logic               r_s1_cout;

    // Stage 1 register: loads whenever it can accept, data only on a transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_p     <= '0;
            r_s1_g     <= '0;
            r_s1_cg    <= '0;
            r_s1_cout  <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_p    <= p;
                r_s1_g    <= g;
                r_s1_cg   <= w_cg[NGRP-1:0];
                r_s1_cout <= w_cg[NGRP];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: per-bit carries, rippled only inside each group
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   w_c;          // carry into each bit
    logic [WIDTH-1:0]   w_sum;

    // Each group is seeded by its registered carry-in; the ripple never
    // crosses a group boundary, so the path is at most GROUP-1 cells deep
    always_comb begin
        w_c = '0;
        for (int i = 0; i < NGRP; i++) begin
            w_c[i*GROUP] = r_s1_cg[i];
            for (int k = 1; k < GROUP; k++) begin
                w_c[i*GROUP+k] = r_s1_g[i*GROUP+k-1]
                               | (r_s1_p[i*GROUP+k-1] & w_c[i*GROUP+k-1]);
            end
        end
    end

    assign w_sum = r_s1_p ^ w_c;

    // The generate of each group's top bit only feeds the next group's
    // carry-in, which the prefix tree already supplies
    logic w_unused_g_top;

    // Fold the group-top generate bits so they are visibly consumed
    always_comb begin
        w_unused_g_top = 1'b0;
        for (int i = 0; i < NGRP; i++) begin
            w_unused_g_top = w_unused_g_top ^ r_s1_g[i*GROUP+GROUP-1];
        end
    end

    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    // Output register: holds while stalled, loads on each stage advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum  <= w_sum;
                r_cout <= r_s1_cout;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

`ifdef ADDER_SUM_FLAGS_EN
    logic r_ovf;
    logic r_zero;
    logic r_neg;

    // Flags load alongside the sum; overflow compares the carries in and out of the MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_adv && r_s1_valid) begin
            r_ovf  <= w_c[WIDTH-1] ^ r_s1_cout;
            r_zero <= (w_sum == '0);
            r_neg  <= w_sum[WIDTH-1];
        end
    end

    assign ovf  = r_ovf;
    assign zero = r_zero;
    assign neg  = r_neg;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
    assign neg  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder_sum_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_sum_stage
// Brief    : Self-checking bench for adder_sum_stage. An operand-level model
//            computes a+b+cin. A monitor compares each drained result and
//            checks output stability while stalled. Directed tests cover
//            ripple, subtract, overflow, back-pressure, throughput and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_sum_stage;

    localparam int WIDTH = 32;
    localparam int GROUP = 4;
    localparam int NGRP  = WIDTH / GROUP;
`ifdef ADDER_SUM_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   p;
    logic [WIDTH-1:0]   g;
    logic               cin;
    logic [2*NGRP-1:0]  q_gp;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               ovf;
    logic               zero;
    logic               neg;

    adder_sum_stage #(.WIDTH(WIDTH), .GROUP(GROUP), .NGRP(NGRP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .p(p), .g(g), .cin(cin), .q_gp(q_gp),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic             neg;
        int               acc;
    } exp_t;

    exp_t               q[$];
    logic [WIDTH-1:0]   popped[$];
    int                 n_chk = 0;
    int                 n_fail = 0;
    int                 cyc = 0;
    int                 acc_count = 0;
    bit                 last_acc = 1'b0;
    bit                 lat_check = 1'b0;
    bit                 post_rst = 1'b0;
    bit                 held = 1'b0;
    logic [WIDTH:0]     held_val;
    logic [WIDTH-1:0]   a_drv, b_drv;
    logic [WIDTH-1:0]   lp_sum;
    logic [3:0]         lp_flags;    // {cout, ovf, zero, neg}

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Prefix pairs as the tree would deliver them: carry-out and all-propagate of bits 0..n-1
    function automatic logic [2*NGRP-1:0] tree(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0]      m;
        logic [WIDTH:0]      t;
        logic [2*NGRP-1:0]   r;
        r = '0;
        for (int i = 0; i < NGRP; i++) begin
            m = ({{WIDTH{1'b0}}, 1'b1} << ((i+1)*GROUP)) - 1'b1;
            t = ({1'b0, a} & m) + ({1'b0, b} & m);
            r[2*i+1] = t[(i+1)*GROUP];
            r[2*i]   = ((({1'b0, a} ^ {1'b0, b}) & m) == m);
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        exp_t           e;
        logic [WIDTH:0] s;
        s      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        e.sum  = s[WIDTH-1:0];
        e.cout = s[WIDTH];
        e.ovf  = FLAGS & (a[WIDTH-1] == b[WIDTH-1]) & (e.sum[WIDTH-1] != a[WIDTH-1]);
        e.zero = FLAGS & (e.sum == '0);
        e.neg  = FLAGS & e.sum[WIDTH-1];
        e.acc  = 0;
        return e;
    endfunction

    // Monitor: samples 1 time unit before each rising edge
    always @(negedge clk) begin
        exp_t e;
        #4;
        cyc++;
        if (rst) begin
            q.delete();
            post_rst = 1'b1;
            held     = 1'b0;
        end else begin
            if (post_rst) begin
                chk("post_reset_state", {out_valid, in_ready, cout, ovf, zero, neg, sum},
                    {1'b0, 1'b1, 4'b0, {WIDTH{1'b0}}});
                post_rst = 1'b0;
            end
            if (held)
                chk("stall_stable", {out_valid, cout, sum}, {1'b1, held_val});
            if (in_valid && in_ready) begin
                e     = model(a_drv, b_drv, cin);
                e.acc = cyc;
                q.push_back(e);
                acc_count++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", {cout, sum}, 0);
                end else begin
                    e = q.pop_front();
                    chk("result", {cout, ovf, zero, neg, sum},
                        {e.cout, e.ovf, e.zero, e.neg, e.sum});
                    if (lat_check)
                        chk("latency", cyc - e.acc, 2);
                end
                lp_sum   = sum;
                lp_flags = {cout, ovf, zero, neg};
                popped.push_back(sum);
            end
            held     = out_valid && !out_ready;
            held_val = {cout, sum};
        end
        last_acc = !rst && in_valid && in_ready;
    end

    // Present one operation from a falling edge; return at the falling edge after it transfers
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        bit done;
        a_drv    = a;
        b_drv    = b;
        p        = a ^ b;
        g        = a & b;
        cin      = c;
        q_gp     = tree(a, b);
        in_valid = 1'b1;
        done     = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge clk);
            done = last_acc;
        end
        if (!done) chk("send_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
        chk("drain_empty", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        p = '0; g = '0; cin = 1'b0; q_gp = '0; a_drv = '0; b_drv = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        @(negedge clk);

        // Carry ripples through every group
        lat_check = 1'b1;
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        drain();
        chk("ripple_sum", lp_sum, 32'h0000_0000);
        chk("ripple_flags", lp_flags, {1'b1, 1'b0, FLAGS, 1'b0});

        // Subtract 5 - 3 through carry-in
        send(32'h0000_0005, 32'hFFFF_FFFC, 1'b1);
        drain();
        chk("sub_sum", lp_sum, 32'h0000_0002);
        chk("sub_flags", lp_flags, 4'b1000);

        // Signed overflow
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        drain();
        chk("ovf_sum", lp_sum, 32'h8000_0000);
        chk("ovf_flags", lp_flags, {1'b0, FLAGS, 1'b0, FLAGS});

        // Back-pressure: four ops, output stalled for 5 clocks
        lat_check = 1'b0;
        popped.delete();
        out_ready = 1'b0;
        base = acc_count;
        fork
            begin
                for (int i = 1; i <= 4; i++) send(i, i, 1'b0);
            end
            begin
                repeat (2) @(negedge clk);
                #2;
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_accepts", acc_count - base, 2);
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", popped.size(), 4);
        if (popped.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("bp_order", popped[i], 2*(i+1));
        end

        // Full throughput: 16 back-to-back ops
        lat_check = 1'b1;
        popped.delete();
        for (int i = 0; i < 16; i++) begin
            send(32'h0101_0101 * i + ((i % 4 == 0) ? 32'h8000_0000 : 32'h0),
                 32'hF0F0_0F0F ^ (32'h1111_1111 * i), i[0]);
        end
        drain();
        chk("tp_count", popped.size(), 16);

        // Reset with both stages full
        lat_check = 1'b0;
        out_ready = 1'b0;
        send(32'd10, 32'd20, 1'b0);
        send(32'd30, 32'd40, 1'b0);
        #2;
        chk("rst_full_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        lat_check = 1'b1;
        popped.delete();
        send(32'd7, 32'd8, 1'b1);
        drain();
        chk("post_rst_count", popped.size(), 1);
        chk("post_rst_sum", lp_sum, 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
